reu_xfer_seq: RTL
=================

// Module: reu_xfer_seq
// PURPOSE
// - DMA transfer sequencer for the REU register file: on Execute it takes the C64 bus via nDMA and runs the
//   transfer type in XferType, one byte per step.
// - Drives C64 bus and REU SRAM strobes, pulses NextCA/NextREUA per byte, and ends with XferEnd or VerifyErr.
// - Sits between the register block (Execute, XferType, Length1 in; Next*/XferEnd/VerifyErr out) and the bus/SRAM pads.
// PARAMETERS
// - DMA_SETUP   default 1  PHI2 cycles between nDMA assert and first byte step (1..7), 3-bit counter
// PORTS
// - PHI2       in   1  single clock; all flops update on falling edge
// - nReset     in   1  synchronous, active-low reset
// - Execute    in   1  start pulse from register block
// - XferType   in   2  00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
// - Length1    in   1  current byte is the last
// - BA         in   1  C64 bus available; low = VIC owns bus, sequencer stalls
// - C64DI      in   8  C64 data bus in
// - RAMDI      in   8  REU SRAM data out
// - nDMA       out  1  C64 DMA request, active low
// - C64RnW     out  1  1 = read C64 bus, 0 = write
// - C64DOE     out  1  drive DO onto C64 data bus
// - RAMnWE     out  1  SRAM write strobe, active low
// - DO         out  8  write data for C64 or SRAM
// - NextCA     out  1  one-cycle pulse: advance C64 address, decrement length
// - NextREUA   out  1  one-cycle pulse: advance REU address
// - XferEnd    out  1  one-cycle pulse: transfer complete
// - VerifyErr  out  1  one-cycle pulse: verify mismatch
// - Busy       out  1  sequencer not in IDLE
// BEHAVIOUR
// - Reset (nReset=0 at a falling edge): state IDLE, nDMA=1, C64RnW=1, C64DOE=0, RAMnWE=1, DO=0, all pulses=0, Busy=0.
//   Reset mid-transfer aborts immediately; no XferEnd.
// - States: IDLE, SETUP, XFER, SWAPWR, DONE.
// - IDLE: Execute=1 -> SETUP, nDMA=0, counter=DMA_SETUP-1. Execute in any other state is ignored.
// - SETUP: decrement counter when BA=1; counter==0 with BA=1 -> XFER.
// - XFER, one step per cycle with BA=1; BA=0 freezes state, DO and counter, strobes inactive, no pulses.
//   - stash: C64RnW=1, RAMnWE=0, SRAM written with C64DI.
//   - fetch: C64RnW=0, C64DOE=1, DO=RAMDI.
//   - verify: C64RnW=1, compare C64DI to RAMDI.
//   - swap: C64RnW=1; latch C64DI into DO and RAMDI into a hold register; -> SWAPWR.
//   - NextCA=NextREUA=1 on each completed byte (stash/fetch/verify in XFER, swap in SWAPWR).
// - SWAPWR (BA=1): C64RnW=0, C64DOE=1 drives the hold byte; RAMnWE=0 writes DO; -> XFER, or DONE if Length1.
// - End conditions:
//   - Length1=1 on a completed byte -> DONE.
//   - verify mismatch -> DONE, error flagged. Failing byte still pulses NextCA/NextREUA.
// - DONE (one cycle): nDMA=1; XferEnd=1 (VerifyErr=1 instead if error flagged, never both) -> IDLE. Length1 is still 1 in DONE.
// - Byte steps per transfer: stash/fetch/verify = L cycles, swap = 2L cycles (L = length); plus DMA_SETUP + 1 cycles.
// CONFIGURATION
// - REU_SWAP_EN defined: swap supported as above.
// - REU_SWAP_EN undefined: SWAPWR and hold register removed; XferType=10 goes SETUP->DONE with no byte steps; XferEnd=1.
// TESTING
// - Reset: nReset=0 for 2 cycles mid-fetch -> nDMA=1, Busy=0, no XferEnd; next Execute starts normally.
// - Stash, L=3, DMA_SETUP=1, BA=1, C64DI=11,22,33 -> SRAM written 11,22,33; 3 NextCA; XferEnd 5 cycles after Execute.
// - Fetch, L=2, BA low 2 cycles mid-transfer -> no strobes or pulses while BA=0; 2 C64 writes total; single XferEnd.
// - Verify, 2nd byte C64DI=5A vs RAMDI=A5 -> 2 NextCA, VerifyErr pulse, no XferEnd, nDMA released.
// - Swap (REU_SWAP_EN), L=1, C64DI=AA, RAMDI=55 -> C64 written 55, SRAM written AA, 1 NextCA, XferEnd.
// - Execute re-pulsed while Busy -> ignored; one XferEnd only.

Source files
------------

// File: rtl/reu_xfer_seq_if.sv
// Register-block and bus/SRAM pad signals of the REU DMA sequencer; master = sequencer side.
// The surrounding register block, C64 bus and SRAM pads attach through the slave modport.
interface reu_xfer_seq_if;
    logic       Execute;
    logic [1:0] XferType;
    logic       Length1;
    logic       BA;
    logic [7:0] C64DI;
    logic [7:0] RAMDI;
    logic       nDMA;
    logic       C64RnW;
    logic       C64DOE;
    logic       RAMnWE;
    logic [7:0] DO;
    logic       NextCA;
    logic       NextREUA;
    logic       XferEnd;
    logic       VerifyErr;
    logic       Busy;

    modport master (
        input  Execute, XferType, Length1, BA, C64DI, RAMDI,
        output nDMA, C64RnW, C64DOE, RAMnWE, DO, NextCA, NextREUA, XferEnd, VerifyErr, Busy
    );

    modport slave (
        output Execute, XferType, Length1, BA, C64DI, RAMDI,
        input  nDMA, C64RnW, C64DOE, RAMnWE, DO, NextCA, NextREUA, XferEnd, VerifyErr, Busy
    );
endinterface

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer (stash/fetch/verify, swap when REU_SWAP_EN is defined), flops on falling PHI2.
// Outputs registered: a byte step sampled at one edge shows its strobes/pulses the following cycle; BA low stalls.
module reu_xfer_seq #(
    parameter int DMA_SETUP = 1
) (
    input  logic              PHI2,
    input  logic              nReset,
    reu_xfer_seq_if.master    bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_SWAPWR,
        ST_DONE
    } state_t;

    localparam logic [1:0] XT_STASH  = 2'b00;
    localparam logic [1:0] XT_FETCH  = 2'b01;
    localparam logic [1:0] XT_SWAP   = 2'b10;
    localparam logic [1:0] XT_VERIFY = 2'b11;
    localparam logic [2:0] SETUP_INIT = 3'(DMA_SETUP - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       ndma_q, ndma_d;
    logic       rnw_q, rnw_d;
    logic       doe_q, doe_d;
    logic       nwe_q, nwe_d;
    logic [7:0] do_q, do_d;
    logic       next_q, next_d;
    logic       end_q, end_d;
    logic       verr_q, verr_d;
    logic       busy_q, busy_d;
`ifdef REU_SWAP_EN
    logic [7:0] hold_q, hold_d;
`endif

    logic mismatch;
    assign mismatch = (bus.C64DI != bus.RAMDI);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ndma_d  = ndma_q;
        do_d    = do_q;
        rnw_d   = 1'b1;
        doe_d   = 1'b0;
        nwe_d   = 1'b1;
        next_d  = 1'b0;
        end_d   = 1'b0;
        verr_d  = 1'b0;
`ifdef REU_SWAP_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.Execute) begin
                    state_d = ST_SETUP;
                    ndma_d  = 1'b0;
                    cnt_d   = SETUP_INIT;
                    err_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (bus.BA) begin
                    if (cnt_q == 3'd0) begin
`ifdef REU_SWAP_EN
                        state_d = ST_XFER;
`else
                        // Swap is not built: a swap request completes with no byte steps.
                        state_d = (bus.XferType == XT_SWAP) ? ST_DONE : ST_XFER;
`endif
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            ST_XFER: begin
                if (bus.BA) begin
                    case (bus.XferType)
                        XT_STASH: begin
                            nwe_d   = 1'b0;
                            do_d    = bus.C64DI;
                            next_d  = 1'b1;
                            if (bus.Length1) state_d = ST_DONE;
                        end
                        XT_FETCH: begin
                            rnw_d   = 1'b0;
                            doe_d   = 1'b1;
                            do_d    = bus.RAMDI;
                            next_d  = 1'b1;
                            if (bus.Length1) state_d = ST_DONE;
                        end
                        XT_VERIFY: begin
                            next_d  = 1'b1;
                            err_d   = mismatch;
                            if (bus.Length1 || mismatch) state_d = ST_DONE;
                        end
                        XT_SWAP: begin
`ifdef REU_SWAP_EN
                            // SRAM was read this edge, so its write of the C64 byte can go out now.
                            nwe_d   = 1'b0;
                            do_d    = bus.C64DI;
                            hold_d  = bus.RAMDI;
                            state_d = ST_SWAPWR;
`else
                            state_d = ST_DONE;
`endif
                        end
                    endcase
                end
            end
`ifdef REU_SWAP_EN
            ST_SWAPWR: begin
                if (bus.BA) begin
                    rnw_d   = 1'b0;
                    doe_d   = 1'b1;
                    do_d    = hold_q;
                    next_d  = 1'b1;
                    state_d = bus.Length1 ? ST_DONE : ST_XFER;
                end
            end
`endif
            ST_DONE: begin
                ndma_d  = 1'b1;
                verr_d  = err_q;
                end_d   = ~err_q;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ndma_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(negedge PHI2) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            ndma_q  <= 1'b1;
            rnw_q   <= 1'b1;
            doe_q   <= 1'b0;
            nwe_q   <= 1'b1;
            do_q    <= 8'h00;
            next_q  <= 1'b0;
            end_q   <= 1'b0;
            verr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef REU_SWAP_EN
            hold_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ndma_q  <= ndma_d;
            rnw_q   <= rnw_d;
            doe_q   <= doe_d;
            nwe_q   <= nwe_d;
            do_q    <= do_d;
            next_q  <= next_d;
            end_q   <= end_d;
            verr_q  <= verr_d;
            busy_q  <= busy_d;
`ifdef REU_SWAP_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.nDMA      = ndma_q;
    assign bus.C64RnW    = rnw_q;
    assign bus.C64DOE    = doe_q;
    assign bus.RAMnWE    = nwe_q;
    assign bus.DO        = do_q;
    assign bus.NextCA    = next_q;
    assign bus.NextREUA  = next_q;
    assign bus.XferEnd   = end_q;
    assign bus.VerifyErr = verr_q;
    assign bus.Busy      = busy_q;

endmodule
